// File: rtl/core_ex_pkg.sv
// Shared EX-stage definitions: ALU opcodes, default watchdog limit and the
// {a_valid, em_valid} slot-state encoding used for debug and assertions.
package core_ex_pkg;

   localparam int CORE_EX_TIMEOUT_DEFAULT = 64;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_AND  = 5'd2,
      ALU_OR   = 5'd3,
      ALU_XOR  = 5'd4,
      ALU_SLL  = 5'd5,
      ALU_SRL  = 5'd6,
      ALU_SRA  = 5'd7,
      ALU_SLT  = 5'd8,
      ALU_SLTU = 5'd9,
      ALU_MUL  = 5'd10,
      ALU_DIV  = 5'd11,
      ALU_REM  = 5'd12
   } alu_op_e;

   // Encoded directly as {a_valid, em_valid}.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      HOLD  = 2'b01,
      ISSUE = 2'b10,
      FULL  = 2'b11
   } slot_state_e;

endpackage

// File: rtl/core_ex_alu_wdog.sv
// Watchdog for one in-flight ALU op: counts stalled issue cycles and requests an
// abort at TIMEOUT_CYCLES-1. Only instantiated with CORE_EX_ALU_CTRL_TIMEOUT_EN.
module core_ex_alu_wdog
   import core_ex_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = CORE_EX_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rest,
   input  logic accept,
   input  logic flush,
   input  logic busy,
   input  logic b_free,
   output logic abort_req
);

   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] count;

   // Saturates at LIMIT so a blocked output slot just delays the abort.
   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         count <= '0;
      end else if (accept || flush) begin
         count <= '0;
      end else if (busy && count != LIMIT) begin
         count <= count + 16'd1;
      end
   end

   assign abort_req = busy && b_free && (count == LIMIT);

endmodule

// File: rtl/core_ex_alu_ctrl.sv
// EX-stage ALU issue/retire sequencer: issue slot A feeds the ALU, output slot B is
// the EX/MEM register. Optional watchdog abort under CORE_EX_ALU_CTRL_TIMEOUT_EN.
module core_ex_alu_ctrl
   import core_ex_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = CORE_EX_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rest,
   input  logic        de_valid,
   output logic        de_ready,
   input  logic [4:0]  de_alu_op,
   input  logic [31:0] de_in1,
   input  logic [31:0] de_in2,
   output logic [4:0]  alu_op,
   output logic        alu_op_valid,
   input  logic        alu_op_ready,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   input  logic [31:0] alu_out,
   output logic        alu_abort,
   output logic        em_valid,
   input  logic        em_ready,
   output logic [31:0] em_result,
   output logic        em_err,
   input  logic        flush_en
);

   logic        a_valid;
   logic [4:0]  a_op;
   logic [31:0] a_in1;
   logic [31:0] a_in2;
   logic        b_free;
   logic        a_fire;
   logic        wd_fire;
   logic        retire;
   logic        accept;
   slot_state_e slot_state;

   assign b_free = !em_valid || em_ready;
   assign a_fire = a_valid && alu_op_ready && b_free;

`ifdef CORE_EX_ALU_CTRL_TIMEOUT_EN
   logic wd_req;

   core_ex_alu_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk      (clk),
      .rest     (rest),
      .accept   (accept),
      .flush    (flush_en),
      .busy     (a_valid && !alu_op_ready),
      .b_free   (b_free),
      .abort_req(wd_req)
   );

   assign wd_fire = wd_req && !flush_en;
`else
   assign wd_fire = 1'b0;
`endif

   // A watchdog retire frees slot A exactly like a normal ALU completion.
   assign retire   = a_fire || wd_fire;
   assign de_ready = !flush_en && (!a_valid || retire);
   assign accept   = de_valid && de_ready;
   assign alu_abort = (flush_en && a_valid && !alu_op_ready) || wd_fire;

   assign alu_op_valid = a_valid;
   assign alu_op       = a_op;
   assign alu_in1      = a_in1;
   assign alu_in2      = a_in2;

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         a_valid   <= 1'b0;
         a_op      <= '0;
         a_in1     <= '0;
         a_in2     <= '0;
         em_valid  <= 1'b0;
         em_result <= '0;
      end else if (flush_en) begin
         a_valid  <= 1'b0;
         em_valid <= 1'b0;
      end else begin
         if (accept) begin
            a_valid <= 1'b1;
            a_op    <= de_alu_op;
            a_in1   <= de_in1;
            a_in2   <= de_in2;
         end else if (retire) begin
            a_valid <= 1'b0;
         end
         if (retire) begin
            em_valid  <= 1'b1;
            em_result <= wd_fire ? 32'h0 : alu_out;
         end else if (em_ready) begin
            em_valid <= 1'b0;
         end
      end
   end

`ifdef CORE_EX_ALU_CTRL_TIMEOUT_EN
   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         em_err <= 1'b0;
      end else if (!flush_en && retire) begin
         em_err <= wd_fire;
      end
   end
`else
   assign em_err = 1'b0;
`endif

   assign slot_state = slot_state_e'({a_valid, em_valid});

`ifndef SYNTHESIS
   // An abort only makes sense while an op sits in slot A.
   always_ff @(posedge clk) begin
      if (rest) begin
         assert (!(alu_abort && (slot_state == EMPTY || slot_state == HOLD))
                 && TIMEOUT_CYCLES >= 2 && TIMEOUT_CYCLES <= 65535);
      end
   end
`endif

endmodule

// File: tb/tb_core_ex_alu_ctrl.sv
// Self-checking bench for core_ex_alu_ctrl: directed scenarios plus randomized
// traffic against an in-order result queue; the bench itself plays the ALU.
module tb_core_ex_alu_ctrl;
   import core_ex_pkg::*;

`ifdef CORE_EX_ALU_CTRL_TIMEOUT_EN
   localparam int TB_TIMEOUT = 8;
`else
   localparam int TB_TIMEOUT = CORE_EX_TIMEOUT_DEFAULT;
`endif

   logic        clk = 1'b0;
   logic        rest = 1'b0;
   logic        de_valid = 1'b0;
   logic        de_ready;
   logic [4:0]  de_alu_op = '0;
   logic [31:0] de_in1 = '0;
   logic [31:0] de_in2 = '0;
   logic [4:0]  alu_op;
   logic        alu_op_valid;
   logic        alu_op_ready = 1'b0;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [31:0] alu_out = '0;
   logic        alu_abort;
   logic        em_valid;
   logic        em_ready = 1'b1;
   logic [31:0] em_result;
   logic        em_err;
   logic        flush_en = 1'b0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] in1;
      logic [31:0] in2;
   } op_t;

   op_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  w = 0;
   int  lat = 0;
   int  lat_mode = 0;
   int  n_cons = 0;
   int  n_abort = 0;

   always #5 clk = ~clk;

   core_ex_alu_ctrl #(
      .TIMEOUT_CYCLES(TB_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rest        (rest),
      .de_valid    (de_valid),
      .de_ready    (de_ready),
      .de_alu_op   (de_alu_op),
      .de_in1      (de_in1),
      .de_in2      (de_in2),
      .alu_op      (alu_op),
      .alu_op_valid(alu_op_valid),
      .alu_op_ready(alu_op_ready),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_out     (alu_out),
      .alu_abort   (alu_abort),
      .em_valid    (em_valid),
      .em_ready    (em_ready),
      .em_result   (em_result),
      .em_err      (em_err),
      .flush_en    (flush_en)
   );

   function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_SLL: return a << b[4:0];
         ALU_SRL: return a >> b[4:0];
         default: return ~a;
      endcase
   endfunction

   function automatic int new_lat();
      return (lat_mode >= 0) ? lat_mode : int'($urandom_range(0, 3));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check at negedge, advance the model, then play the ALU after posedge.
   task automatic cycle();
      logic acc;
      logic cons;
      logic take;
      int   idx;
      @(negedge clk);
      acc  = de_valid && de_ready;
      cons = em_valid && em_ready && !flush_en;
      take = alu_op_valid && alu_op_ready && (!em_valid || em_ready) && !flush_en;
      n_abort += int'(alu_abort);
      chk("occupancy", 32'(alu_op_valid) + 32'(em_valid), 32'(exp_q.size()));
      if (flush_en) chk("de_ready_flush", 32'(de_ready), 32'd0);
      else if (!alu_op_valid) chk("de_ready_idle", 32'(de_ready), 32'd1);
`ifndef CORE_EX_ALU_CTRL_TIMEOUT_EN
      chk("alu_abort", 32'(alu_abort), 32'(flush_en && alu_op_valid && !alu_op_ready));
`endif
      idx = em_valid ? 1 : 0;
      if (alu_op_valid && exp_q.size() > idx) begin
         chk("alu_op", 32'(alu_op), 32'(exp_q[idx].op));
         chk("alu_in1", alu_in1, exp_q[idx].in1);
         chk("alu_in2", alu_in2, exp_q[idx].in2);
      end
      if (cons && exp_q.size() > 0) begin
         chk("em_result", em_result, alu_f(exp_q[0].op, exp_q[0].in1, exp_q[0].in2));
         chk("em_err", 32'(em_err), 32'd0);
         n_cons++;
      end
      if (flush_en) begin
         exp_q.delete();
         w   = 0;
         lat = new_lat();
      end else begin
         if (cons) void'(exp_q.pop_front());
         if (acc) exp_q.push_back('{de_alu_op, de_in1, de_in2});
         if (take) begin
            w   = 0;
            lat = new_lat();
         end else if (alu_op_valid) begin
            w++;
         end
      end
      @(posedge clk);
      #1;
      alu_op_ready = alu_op_valid && (w >= lat);
      alu_out      = alu_op_ready ? alu_f(alu_op, alu_in1, alu_in2) : $urandom();
      #1;
   endtask

   initial begin
      logic [5:0]  pat;
      logic [31:0] seen;
      int          low_cnt;
      int          val_cnt;
      int          stable;
      int          n0;

      // Reset state
      cycle();
      cycle();
      chk("rst_em_valid", 32'(em_valid), 32'd0);
      chk("rst_em_result", em_result, 32'h0);
      chk("rst_em_err", 32'(em_err), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_alu_abort", 32'(alu_abort), 32'd0);
      chk("rst_de_ready", 32'(de_ready), 32'd1);
      chk("rst_alu_valid", 32'(alu_op_valid), 32'd0);
      rest = 1'b1;
      cycle();

      // Single-cycle ADD 5+7
      lat_mode = 0;
      lat = 0;
      em_ready = 1'b1;
      de_valid = 1'b1;
      de_alu_op = ALU_ADD;
      de_in1 = 32'd5;
      de_in2 = 32'd7;
      cycle();
      de_valid = 1'b0;
      chk("t1_issue", 32'(alu_op_valid), 32'd1);
      cycle();
      chk("t1_valid", 32'(em_valid), 32'd1);
      chk("t1_result", em_result, 32'd12);
      chk("t1_err", 32'(em_err), 32'd0);
      cycle();
      chk("t1_drain", 32'(em_valid), 32'd0);

      // Back-to-back: four ops, four consecutive results
      pat = '0;
      for (int i = 0; i < 6; i++) begin
         de_valid = (i < 4);
         de_alu_op = 5'(i);
         de_in1 = $urandom();
         de_in2 = $urandom();
         if (i < 4) chk("b2b_de_ready", 32'(de_ready), 32'd1);
         cycle();
         pat[i] = em_valid;
      end
      de_valid = 1'b0;
      chk("b2b_pattern", 32'(pat), 32'b011110);

`ifndef CORE_EX_ALU_CTRL_TIMEOUT_EN
      // Multi-cycle: ready on the 10th cycle of alu_op_valid
      lat_mode = 9;
      lat = 9;
      de_valid = 1'b1;
      de_alu_op = ALU_ADD;
      de_in1 = 32'hDEAD_0000;
      de_in2 = 32'h0000_BEEF;
      cycle();
      de_valid = 1'b0;
      low_cnt = 0;
      val_cnt = 0;
      stable = 1;
      seen = '0;
      n0 = n_cons;
      for (int i = 0; i < 12; i++) begin
         low_cnt += int'(!de_ready);
         val_cnt += int'(alu_op_valid);
         if (alu_op_valid && (alu_in1 !== 32'hDEAD_0000 || alu_in2 !== 32'h0000_BEEF
                              || alu_op !== ALU_ADD)) stable = 0;
         if (em_valid) seen = em_result;
         cycle();
      end
      chk("mc_de_ready_low", 32'(low_cnt), 32'd9);
      chk("mc_valid_cycles", 32'(val_cnt), 32'd10);
      chk("mc_stable", 32'(stable), 32'd1);
      chk("mc_result", seen, 32'hDEAD_BEEF);
      chk("mc_retired", 32'(n_cons - n0), 32'd1);
`endif

      // Backpressure: B full, A complete, em_ready low for 5 cycles
      lat_mode = 0;
      lat = 0;
      em_ready = 1'b0;
      de_valid = 1'b1;
      de_alu_op = ALU_SUB;
      de_in1 = 32'd100;
      de_in2 = 32'd1;
      cycle();
      de_alu_op = ALU_XOR;
      de_in1 = 32'h0000_F0F0;
      de_in2 = 32'h0000_0FF0;
      cycle();
      de_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_alu_valid", 32'(alu_op_valid), 32'd1);
         chk("bp_de_ready", 32'(de_ready), 32'd0);
         chk("bp_first", em_result, 32'd99);
         cycle();
      end
      em_ready = 1'b1;
      cycle();
      chk("bp_second_valid", 32'(em_valid), 32'd1);
      chk("bp_second", em_result, 32'h0000_FF00);
      cycle();
      chk("bp_empty", 32'(em_valid), 32'd0);

      // Flush three cycles into a multi-cycle op
      lat_mode = 9;
      lat = 9;
      de_valid = 1'b1;
      de_alu_op = ALU_ADD;
      de_in1 = 32'd1;
      de_in2 = 32'd1;
      cycle();
      de_valid = 1'b0;
      cycle();
      cycle();
      n0 = n_abort;
      flush_en = 1'b1;
      #1;
      chk("fl_abort_now", 32'(alu_abort), 32'd1);
      cycle();
      flush_en = 1'b0;
      chk("fl_a_clear", 32'(alu_op_valid), 32'd0);
      chk("fl_b_clear", 32'(em_valid), 32'd0);
      chk("fl_pulses", 32'(n_abort - n0), 32'd1);
      lat_mode = 0;
      lat = 0;
      de_valid = 1'b1;
      de_in1 = 32'd20;
      de_in2 = 32'd22;
      cycle();
      de_valid = 1'b0;
      chk("fl_reissue", 32'(alu_op_valid), 32'd1);
      cycle();
      chk("fl_next_valid", 32'(em_valid), 32'd1);
      chk("fl_next_result", em_result, 32'd42);
      cycle();
      chk("fl_pulses_total", 32'(n_abort - n0), 32'd1);

`ifdef CORE_EX_ALU_CTRL_TIMEOUT_EN
      // Watchdog: ALU never ready, abort on the 8th issue cycle
      lat_mode = 1000;
      lat = 1000;
      em_ready = 1'b0;
      de_valid = 1'b1;
      de_alu_op = ALU_ADD;
      de_in1 = 32'd3;
      de_in2 = 32'd4;
      cycle();
      de_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         chk("to_abort", 32'(alu_abort), 32'(k == 8));
         if (k < 8) cycle();
      end
      cycle();
      chk("to_valid", 32'(em_valid), 32'd1);
      chk("to_err", 32'(em_err), 32'd1);
      chk("to_result", em_result, 32'h0);
      chk("to_a_clear", 32'(alu_op_valid), 32'd0);
      flush_en = 1'b1;
      cycle();
      flush_en = 1'b0;
`endif

      // Randomized traffic with random ALU latency, backpressure and flushes
      lat_mode = -1;
      lat = new_lat();
      repeat (400) begin
         de_valid = ($urandom_range(0, 3) != 0);
         de_alu_op = 5'($urandom_range(0, 7));
         de_in1 = $urandom();
         de_in2 = $urandom();
         em_ready = ($urandom_range(0, 3) != 0);
         flush_en = ($urandom_range(0, 19) == 0);
         cycle();
      end
      de_valid = 1'b0;
      flush_en = 1'b0;
      em_ready = 1'b1;
      repeat (20) cycle();
      chk("drain", 32'(exp_q.size()), 32'd0);
      chk("consumed_any", 32'(n_cons > 10), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
